reg_muldiv_unit: RTL and testbench

- Iterative 32-bit unsigned multiply/divide unit in the multi-cycle CPU datapath.
- Sits directly downstream of the 8x32 register file. It consumes the two read-port values QA/QB and drives the file's write port (WE, Addr_W, Di) to write back the low result.
- The upper half of the product, or the remainder, is held in an internal HI register exposed on a port.
- The control FSM raises start and then waits for done.

---
 rtl/reg_muldiv_unit_if.sv | 28 ++
 rtl/reg_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_reg_muldiv_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_muldiv_unit_if.sv
// rtl/reg_muldiv_unit_if.sv - register-file side bundle of the multiply/divide unit
// master: control FSM / register file side (drives start, op, QA, QB, dst)
// slave : reg_muldiv_unit (drives busy, done, WE, Addr_W, Di, HI)
interface reg_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] QA;
   logic [WIDTH-1:0] QB;
   logic [2:0]       dst;
   logic             busy;
   logic             done;
   logic             WE;
   logic [2:0]       Addr_W;
   logic [WIDTH-1:0] Di;
   logic [WIDTH-1:0] HI;

   modport master (
      output start, op, QA, QB, dst,
      input  busy, done, WE, Addr_W, Di, HI
   );

   modport slave (
      input  start, op, QA, QB, dst,
      output busy, done, WE, Addr_W, Di, HI
   );
endinterface

// File: rtl/reg_muldiv_unit.sv
// rtl/reg_muldiv_unit.sv - iterative 32-bit unsigned multiply/divide unit
// Ports:
//   clk        rising-edge clock shared with the register file
//   cr         asynchronous active-low reset
//   bus.start  launch request, sampled in IDLE (and in WB for back-to-back)
//   bus.op     0 = unsigned multiply, 1 = unsigned divide
//   bus.QA/QB  operands from register file read ports A/B
//   bus.dst    destination register index for the low result
//   bus.busy   high while in CALC or WB
//   bus.done   one-cycle completion pulse, coincident with WE
//   bus.WE     register-file write enable
//   bus.Addr_W register-file write address (latched dst)
//   bus.Di     product[31:0] or quotient
//   bus.HI     product[63:32] or remainder, held until the next completion
module reg_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic               clk,
   input logic               cr,
   reg_muldiv_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             op_q, op_d;
   // Multiplicand for multiply, divisor for divide.
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // Accumulator: hi half is partial product / partial remainder; lo half
   // starts as the multiplier / dividend and shifts out as result bits shift in.
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [2:0]       addr_w_q, addr_w_d;
   logic [WIDTH-1:0] di_q, di_d;
   logic [WIDTH-1:0] hi_q, hi_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_lo;
   logic             accept;

   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      iter_hi   = acc_hi_q;
      iter_lo   = acc_lo_q;
      if (!op_q) begin
         if (acc_lo_q[0]) begin
            {iter_hi, iter_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
         end else begin
            {iter_hi, iter_lo} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
         end
      end else begin
         // Divisor of zero always "fits", giving all-ones quotient and
         // leaving the dividend as remainder.
         if (div_shift >= {1'b0, opnd_q}) begin
            iter_hi = div_diff[WIDTH-1:0];
            iter_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
         end else begin
            iter_hi = div_shift[WIDTH-1:0];
            iter_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // A launch is taken from IDLE, and also from WB so a new operation can
   // start on the same edge that retires the previous one.
   assign accept = bus.start && (state_q == IDLE || state_q == WB);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      addr_w_d = addr_w_q;
      di_d     = di_q;
      hi_d     = hi_q;

      case (state_q)
         IDLE: state_d = IDLE;
         CALC: begin
            acc_hi_d = iter_hi;
            acc_lo_d = iter_lo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = WB;
               di_d    = iter_lo;
               hi_d    = iter_hi;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d  = CALC;
         cnt_d    = '0;
         op_d     = bus.op;
         opnd_d   = bus.op ? bus.QB : bus.QA;
         acc_hi_d = '0;
         acc_lo_d = bus.op ? bus.QA : bus.QB;
         addr_w_d = bus.dst;
      end
   end

   always_ff @(posedge clk or negedge cr) begin
      if (!cr) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         addr_w_q <= '0;
         di_q     <= '0;
         hi_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         addr_w_q <= addr_w_d;
         di_q     <= di_d;
         hi_q     <= hi_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == WB);
   assign bus.WE     = (state_q == WB);
   assign bus.Addr_W = addr_w_q;
   assign bus.Di     = di_q;
   assign bus.HI     = hi_q;

endmodule

// File: tb/tb_reg_muldiv_unit.sv
// tb/tb_reg_muldiv_unit.sv - self-checking bench for reg_muldiv_unit
module tb_reg_muldiv_unit;

   logic clk = 1'b0;
   logic cr  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   reg_muldiv_unit_if #(.WIDTH(32)) bus ();

   reg_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk (clk),
      .cr  (cr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi);
      logic [63:0] p;
      if (!o) begin
         p  = 64'(a) * 64'(b);
         lo = p[31:0];
         hi = p[63:32];
      end else if (b == 0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   // Launch one operation and observe 40 cycles after the accepting edge.
   task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] d, output int we_at, output int we_n,
                        output int busy_bad, output int done_bad,
                        output logic [31:0] di, output logic [31:0] hi,
                        output logic [2:0] aw);
      bus.start = 1'b1; bus.op = o; bus.QA = a; bus.QB = b; bus.dst = d;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.QA = $urandom; bus.QB = $urandom; bus.op = 1'($urandom); bus.dst = 3'($urandom);
      we_at = -1; we_n = 0; busy_bad = 0; done_bad = 0; di = 'x; hi = 'x; aw = 'x;
      if (bus.busy !== 1'b1) busy_bad++;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.busy !== (k <= 32)) busy_bad++;
         if (bus.done !== bus.WE) done_bad++;
         if (bus.WE === 1'b1) begin
            we_n++;
            if (we_at < 0) begin
               we_at = k; di = bus.Di; hi = bus.HI; aw = bus.Addr_W;
            end
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.op = 0; bus.QA = 0; bus.QB = 0; bus.dst = 0;
      #2 cr = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.done, bus.WE} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {bus.busy, bus.done, bus.WE}); end
      checks++; if (bus.Di !== 32'h0 || bus.HI !== 32'h0) begin errors++; $display("FAIL reset_data: got Di=%h HI=%h expected 0", bus.Di, bus.HI); end
      checks++; if (bus.Addr_W !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.Addr_W); end
      repeat (2) @(posedge clk);
      #1 cr = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_mul_basic();
      int we_at, we_n, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      do_op(1'b0, 32'd7, 32'd6, 3'd3, we_at, we_n, bb, db, di, hi, aw);
      checks++; if (we_at !== 32) begin errors++; $display("FAIL mul_latency: got %0d expected 32", we_at); end
      checks++; if (we_n !== 1) begin errors++; $display("FAIL mul_we_count: got %0d expected 1", we_n); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL mul_busy_profile: got %0d bad cycles expected 0", bb); end
      checks++; if (db !== 0) begin errors++; $display("FAIL mul_done_we: got %0d bad cycles expected 0", db); end
      checks++; if (aw !== 3'd3) begin errors++; $display("FAIL mul_addr: got %0d expected 3", aw); end
      checks++; if (di !== 32'd42 || hi !== 32'd0) begin errors++; $display("FAIL mul_result: got Di=%h HI=%h expected 2a/0", di, hi); end
      checks++; if (bus.Di !== 32'd42 || bus.HI !== 32'd0) begin errors++; $display("FAIL mul_hold: got Di=%h HI=%h expected 2a/0", bus.Di, bus.HI); end
   endtask

   task automatic test_mul_overflow();
      int we_at, we_n, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, we_at, we_n, bb, db, di, hi, aw);
      checks++; if (di !== 32'h0000_0001 || hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_overflow: got Di=%h HI=%h expected 00000001/fffffffe", di, hi); end
      checks++; if (we_at !== 32 || we_n !== 1) begin errors++; $display("FAIL mul_overflow_we: got at=%0d n=%0d expected 32/1", we_at, we_n); end
   endtask

   task automatic test_div();
      int we_at, we_n, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      do_op(1'b1, 32'd100, 32'd7, 3'd5, we_at, we_n, bb, db, di, hi, aw);
      checks++; if (di !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL div_result: got Di=%0d HI=%0d expected 14/2", di, hi); end
      checks++; if (aw !== 3'd5) begin errors++; $display("FAIL div_addr: got %0d expected 5", aw); end
      checks++; if (we_n !== 1 || we_at !== 32) begin errors++; $display("FAIL div_we: got at=%0d n=%0d expected 32/1", we_at, we_n); end
   endtask

   task automatic test_div_zero();
      int we_at, we_n, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      do_op(1'b1, 32'h0000_1234, 32'h0, 3'd1, we_at, we_n, bb, db, di, hi, aw);
      checks++; if (di !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin errors++; $display("FAIL div_zero: got Di=%h HI=%h expected ffffffff/00001234", di, hi); end
      checks++; if (we_at !== 32 || we_n !== 1) begin errors++; $display("FAIL div_zero_we: got at=%0d n=%0d expected 32/1", we_at, we_n); end
   endtask

   task automatic test_random();
      int we_at, we_n, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      logic o; logic [31:0] a, b, elo, ehi; logic [2:0] d;
      for (int i = 0; i < 24; i++) begin
         o = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 15));
            1:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         d = 3'($urandom);
         model(o, a, b, elo, ehi);
         do_op(o, a, b, d, we_at, we_n, bb, db, di, hi, aw);
         checks++; if (di !== elo || hi !== ehi) begin errors++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h/%h expected %h/%h", i, o, a, b, di, hi, elo, ehi); end
         checks++; if (aw !== d) begin errors++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", i, aw, d); end
         checks++; if (we_at !== 32 || we_n !== 1 || bb !== 0 || db !== 0) begin errors++; $display("FAIL rand_timing[%0d]: got at=%0d n=%0d busy_bad=%0d done_bad=%0d expected 32/1/0/0", i, we_at, we_n, bb, db); end
      end
   endtask

   task automatic test_start_while_busy();
      int we_at = -1, we_n = 0; logic [31:0] di = 'x, hi = 'x; logic [2:0] aw = 'x;
      bus.start = 1'b1; bus.op = 1'b1; bus.QA = 32'd100; bus.QB = 32'd7; bus.dst = 3'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.WE === 1'b1) begin
            we_n++;
            if (we_at < 0) begin we_at = k; di = bus.Di; hi = bus.HI; aw = bus.Addr_W; end
         end
         if (k == 10) begin
            bus.start = 1'b1; bus.op = 1'b0; bus.QA = 32'd9; bus.QB = 32'd9; bus.dst = 3'd1;
         end
         if (k == 11) bus.start = 1'b0;
      end
      checks++; if (di !== 32'd14 || hi !== 32'd2 || aw !== 3'd5) begin errors++; $display("FAIL busy_start_result: got %0d/%0d @%0d expected 14/2 @5", di, hi, aw); end
      checks++; if (we_at !== 32 || we_n !== 1) begin errors++; $display("FAIL busy_start_we: got at=%0d n=%0d expected 32/1", we_at, we_n); end
   endtask

   task automatic test_back_to_back();
      int we1 = -1, we2 = -1, we_n = 0; logic [31:0] di1 = 'x, di2 = 'x, hi2 = 'x; logic [2:0] aw2 = 'x;
      logic busy33 = 1'b0;
      bus.start = 1'b1; bus.op = 1'b1; bus.QA = 32'd100; bus.QB = 32'd7; bus.dst = 3'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= 75; k++) begin
         @(posedge clk); #1;
         if (bus.WE === 1'b1) begin
            we_n++;
            if (we1 < 0) begin we1 = k; di1 = bus.Di; end
            else if (we2 < 0) begin we2 = k; di2 = bus.Di; hi2 = bus.HI; aw2 = bus.Addr_W; end
         end
         if (k == 32) begin
            bus.start = 1'b1; bus.op = 1'b0; bus.QA = 32'h0001_0000; bus.QB = 32'h0003_0000; bus.dst = 3'd6;
         end
         if (k == 33) begin
            busy33 = bus.busy;
            bus.start = 1'b0; bus.QA = $urandom; bus.QB = $urandom;
         end
      end
      checks++; if (busy33 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy33); end
      checks++; if (we1 !== 32 || we2 - we1 !== 33 || we_n !== 2) begin errors++; $display("FAIL b2b_spacing: got we1=%0d we2=%0d n=%0d expected 32/65/2", we1, we2, we_n); end
      checks++; if (di1 !== 32'd14 || di2 !== 32'd0 || hi2 !== 32'd3 || aw2 !== 3'd6) begin errors++; $display("FAIL b2b_result: got %h %h/%h @%0d expected e 0/3 @6", di1, di2, hi2, aw2); end
   endtask

   task automatic test_abort();
      int we_n = 0, we_at, n2, bb, db; logic [31:0] di, hi; logic [2:0] aw;
      bus.start = 1'b1; bus.op = 1'b0; bus.QA = 32'd11; bus.QB = 32'd13; bus.dst = 3'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (bus.WE === 1'b1) we_n++;
      end
      cr = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.WE !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b WE=%b done=%b expected 0", bus.busy, bus.WE, bus.done); end
      checks++; if (bus.Di !== 32'h0 || bus.HI !== 32'h0) begin errors++; $display("FAIL abort_clear: got Di=%h HI=%h expected 0", bus.Di, bus.HI); end
      repeat (3) @(posedge clk);
      #1 cr = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.WE === 1'b1 || bus.busy === 1'b1) we_n++;
      end
      checks++; if (we_n !== 0) begin errors++; $display("FAIL abort_no_wb: got %0d active cycles expected 0", we_n); end
      do_op(1'b0, 32'd3, 32'd5, 3'd4, we_at, n2, bb, db, di, hi, aw);
      checks++; if (di !== 32'd15 || hi !== 32'd0 || aw !== 3'd4 || we_at !== 32) begin errors++; $display("FAIL abort_recover: got %0d/%0d @%0d at=%0d expected 15/0 @4 at=32", di, hi, aw, we_at); end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mul_overflow();
      test_div();
      test_div_zero();
      test_random();
      test_start_while_busy();
      test_back_to_back();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
